// File: rtl/cnn_params.sv
// Shared CNN layer parameters and size derivations.
// Used by the pooling stage and its line buffer.
package cnn_params;

    localparam int DATA_WIDTH_DEF  = 16;
    localparam int FRAC_BIT_DEF    = 8;
    localparam int KERNEL_SIZE_DEF = 5;
    localparam int IMAGE_SIZE_DEF  = 28;

    function automatic int f_conv_size(input int img, input int k);
        return img - k + 1;
    endfunction

    function automatic int f_pool_size(input int conv);
        return conv / 2;
    endfunction

    function automatic int f_cnt_width(input int conv);
        return (conv < 2) ? 1 : $clog2(conv);
    endfunction

    function automatic int f_addr_width(input int pool);
        return (pool < 2) ? 1 : $clog2(pool);
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One-row buffer of horizontal pair maxima for the 2x2 pool.
// Synchronous write, combinational read.
module pool_line_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 12,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Store the even-row pair max for later column match-up.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/max_pool_stage.sv
// Streaming 2x2 stride-2 signed max pool over a raster stream.
// Define RELU_POOL_EN to clamp negative inputs to zero first.
module max_pool_stage
    import cnn_params::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int FRAC_BIT    = FRAC_BIT_DEF,
    parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
    parameter int IMAGE_SIZE  = IMAGE_SIZE_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    output logic [DATA_WIDTH-1:0] pool_out,
    output logic                  out_valid,
    output logic                  frame_done
);

    localparam int CONV_SIZE = f_conv_size(IMAGE_SIZE, KERNEL_SIZE);
    localparam int POOL_SIZE = f_pool_size(CONV_SIZE);
    localparam int CW        = f_cnt_width(CONV_SIZE);
    localparam int AW        = f_addr_width(POOL_SIZE);

    localparam logic [CW-1:0] CNT_LAST = CW'(CONV_SIZE - 1);
    localparam logic [CW-1:0] WIN_LAST = CW'(2 * POOL_SIZE - 1);

    // Fixed-point format is carried, never interpreted here.
    if (FRAC_BIT < 0 || FRAC_BIT >= DATA_WIDTH) begin : g_bad_frac
        $error("FRAC_BIT out of range");
    end
    if (CONV_SIZE < 2) begin : g_bad_conv
        $error("CONV_SIZE must be at least 2");
    end

    logic [CW-1:0]         r_col;
    logic [CW-1:0]         r_row;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] r_pool;
    logic                  r_ov;
    logic                  r_fd;

    logic [DATA_WIDTH-1:0] w_pix;
    logic [DATA_WIDTH-1:0] w_pair;
    logic [DATA_WIDTH-1:0] w_lb_rd;
    logic [DATA_WIDTH-1:0] w_win;
    logic [AW-1:0]         w_addr;
    logic                  w_lb_we;
    logic                  w_last;

`ifdef RELU_POOL_EN
    assign w_pix = pixel_in[DATA_WIDTH-1] ? '0 : pixel_in;
`else
    assign w_pix = pixel_in;
`endif

    assign w_pair  = ($signed(w_pix) > $signed(r_hold)) ? w_pix : r_hold;
    assign w_win   = ($signed(w_pair) > $signed(w_lb_rd)) ? w_pair : w_lb_rd;
    assign w_addr  = AW'(r_col >> 1);
    assign w_lb_we = reset & in_valid & r_col[0] & ~r_row[0];
    assign w_last  = (r_row == WIN_LAST) && (r_col == WIN_LAST);

    pool_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (POOL_SIZE),
        .AW         (AW)
    ) u_line_buf (
        .clk     (clk),
        .i_we    (w_lb_we),
        .i_waddr (w_addr),
        .i_wdata (w_pair),
        .i_raddr (w_addr),
        .o_rdata (w_lb_rd)
    );

    // Raster counters, pair hold and registered window output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_col  <= '0;
            r_row  <= '0;
            r_hold <= '0;
            r_pool <= '0;
            r_ov   <= 1'b0;
            r_fd   <= 1'b0;
        end else begin
            r_ov <= 1'b0;
            r_fd <= 1'b0;
            if (in_valid) begin
                if (r_col == CNT_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == CNT_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                if (!r_col[0]) begin
                    r_hold <= w_pix;
                end else if (r_row[0]) begin
                    r_pool <= w_win;
                    r_ov   <= 1'b1;
                    r_fd   <= w_last;
                end
            end
        end
    end

    assign pool_out   = r_pool;
    assign out_valid  = r_ov;
    assign frame_done = r_fd;

endmodule

// File: tb/tb_max_pool_stage.sv
// Directed bench for max_pool_stage (24x24 default and 5x5 instance).
// Expected values are hand-derived closed forms per window.
module tb_max_pool_stage;

`ifdef RELU_POOL_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] pixel_in;
    logic [15:0] pool_out;
    logic        out_valid;
    logic        frame_done;
    logic        in_valid2;
    logic [15:0] pixel2;
    logic [15:0] pool2;
    logic        ov2;
    logic        fd2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [15:0] q_val[$];
    logic        q_fd[$];
    int          q_cyc[$];
    int          q_exp_cyc[$];
    logic [15:0] q2_val[$];
    logic        q2_fd[$];

    always #5 clk = ~clk;

    max_pool_stage dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .pixel_in   (pixel_in),
        .pool_out   (pool_out),
        .out_valid  (out_valid),
        .frame_done (frame_done)
    );

    max_pool_stage #(
        .IMAGE_SIZE  (8),
        .KERNEL_SIZE (4)
    ) dut2 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid2),
        .pixel_in   (pixel2),
        .pool_out   (pool2),
        .out_valid  (ov2),
        .frame_done (fd2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            q_val.push_back(pool_out);
            q_fd.push_back(frame_done);
            q_cyc.push_back(cyc);
        end
        if (ov2) begin
            q2_val.push_back(pool2);
            q2_fd.push_back(fd2);
        end
    end

    function automatic logic [15:0] pix(input int mode, input int r, input int c);
        logic [15:0] w0 [4];
        logic [15:0] w1 [4];
        w0 = '{16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF};
        w1 = '{16'h8000, 16'hFFFE, 16'h8001, 16'hFFFF};
        case (mode)
            0: return 16'(r * 24 + c);
            1: return 16'(-(r * 24 + c) - 1);
            default: begin
                if (r < 2 && c < 2) return w0[r * 2 + c];
                if (r < 2 && c < 4) return w1[r * 2 + c - 2];
                return 16'h0000;
            end
        endcase
    endfunction

    function automatic logic [15:0] expv(input int mode, input int pr, input int pc);
        case (mode)
            0: return 16'((2 * pr + 1) * 24 + 2 * pc + 1);
            1: return RELU ? 16'h0000 : 16'(-(2 * pr * 24 + 2 * pc) - 1);
            default: begin
                if (pr == 0 && pc == 0) return 16'h7FFF;
                if (pr == 0 && pc == 1) return RELU ? 16'h0000 : 16'hFFFF;
                return 16'h0000;
            end
        endcase
    endfunction

    task automatic clear_q();
        q_val.delete();
        q_fd.delete();
        q_cyc.delete();
        q_exp_cyc.delete();
        q2_val.delete();
        q2_fd.delete();
    endtask

    task automatic drive_frame(input int mode, input bit gap, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            pixel_in = pix(mode, i / 24, i % 24);
            if ((i / 24) % 2 == 1 && (i % 24) % 2 == 1)
                q_exp_cyc.push_back(cyc + 1);
            if (gap) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_valid = 1'b1;
        pixel_in = 16'h1234;
        in_valid2 = 1'b1;
        pixel2 = 16'h0042;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pool_out !== 16'h0 || out_valid !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %h/%b/%b want 0000/0/0",
                     pool_out, out_valid, frame_done);
        end
        checks++;
        if (pool2 !== 16'h0 || ov2 !== 1'b0 || fd2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs2: got %h/%b/%b want 0000/0/0", pool2, ov2, fd2);
        end
        in_valid = 1'b0;
        in_valid2 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        clear_q();
    endtask

    task automatic test_frame(input string name, input int mode, input bit gap);
        clear_q();
        drive_frame(mode, gap, 576);
        checks++;
        if (q_val.size() != 144) begin
            failures++;
            $display("FAIL %s_count: got %0d want 144", name, q_val.size());
        end
        for (int i = 0; i < q_val.size() && i < 144; i++) begin
            checks++;
            if (q_val[i] !== expv(mode, i / 12, i % 12)) begin
                failures++;
                $display("FAIL %s_val[%0d]: got %h want %h",
                         name, i, q_val[i], expv(mode, i / 12, i % 12));
            end
            checks++;
            if (q_fd[i] !== (i == 143)) begin
                failures++;
                $display("FAIL %s_fd[%0d]: got %b want %b", name, i, q_fd[i], i == 143);
            end
            checks++;
            if (q_cyc[i] != q_exp_cyc[i]) begin
                failures++;
                $display("FAIL %s_lat[%0d]: got cycle %0d want %0d",
                         name, i, q_cyc[i], q_exp_cyc[i]);
            end
        end
    endtask

    task automatic test_signed();
        clear_q();
        drive_frame(2, 1'b0, 576);
        checks++;
        if (q_val.size() != 144) begin
            failures++;
            $display("FAIL signed_count: got %0d want 144", q_val.size());
        end
        for (int i = 0; i < q_val.size() && i < 3; i++) begin
            checks++;
            if (q_val[i] !== expv(2, 0, i)) begin
                failures++;
                $display("FAIL signed_val[%0d]: got %h want %h", i, q_val[i], expv(2, 0, i));
            end
        end
    endtask

    task automatic test_mid_reset();
        clear_q();
        drive_frame(0, 1'b0, 300);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || pool_out !== 16'h0) begin
            failures++;
            $display("FAIL midreset_outputs: got %b/%h want 0/0000", out_valid, pool_out);
        end
        reset = 1'b1;
        clear_q();
        drive_frame(0, 1'b0, 576);
        checks++;
        if (q_val.size() != 144) begin
            failures++;
            $display("FAIL midreset_count: got %0d want 144", q_val.size());
        end
        for (int i = 0; i < q_val.size() && i < 144; i++) begin
            checks++;
            if (q_val[i] !== expv(0, i / 12, i % 12) || q_fd[i] !== (i == 143)) begin
                failures++;
                $display("FAIL midreset_val[%0d]: got %h/%b want %h/%b",
                         i, q_val[i], q_fd[i], expv(0, i / 12, i % 12), i == 143);
            end
        end
    endtask

    task automatic test_small();
        logic [15:0] exp4 [4];
        exp4 = '{16'd6, 16'd8, 16'd16, 16'd18};
        clear_q();
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            in_valid2 = 1'b1;
            pixel2 = 16'(i);
        end
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (q2_val.size() != 4) begin
            failures++;
            $display("FAIL small_count: got %0d want 4", q2_val.size());
        end
        for (int i = 0; i < q2_val.size() && i < 4; i++) begin
            checks++;
            if (q2_val[i] !== exp4[i] || q2_fd[i] !== (i == 3)) begin
                failures++;
                $display("FAIL small_val[%0d]: got %0d/%b want %0d/%b",
                         i, q2_val[i], q2_fd[i], exp4[i], i == 3);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        pixel_in = '0;
        in_valid2 = 1'b0;
        pixel2 = '0;
        test_reset();
        test_frame("ramp", 0, 1'b0);
        test_frame("negative", 1, 1'b0);
        test_frame("toggle", 0, 1'b1);
        test_signed();
        test_mid_reset();
        test_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
